// File: rtl/amp_share_pkg.sv
// amp_share_pkg: state encoding and index helpers shared by the amplifier share scheduler
package amp_share_pkg;
  localparam int MAX_REQ = 16;
  typedef enum logic [2:0] {IDLE, PROG, SETTLE, SAMPLE, HOLD} state_e;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic [MAX_REQ-1:0] onehot(input int i);
    return MAX_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/amp_share_scheduler_if.sv
// amp_share_scheduler_if: requester side and shared amplifier configuration bundle
interface amp_share_scheduler_if import amp_share_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int GAIN_W = 8,
  parameter int SETTLE_W = 8,
  localparam int IDX_W = idx_w(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ*GAIN_W-1:0] req_gain;
  logic [SETTLE_W-1:0] settle_cycles;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] amp_sel;
  logic [GAIN_W-1:0] amp_gain;
  logic amp_gain_we;
  logic amp_en;
  logic sample;
  logic [N_REQ-1:0] done;
  logic busy;
  modport master (
    output req, req_gain, settle_cycles,
    input grant, amp_sel, amp_gain, amp_gain_we, amp_en, sample, done, busy
  );
  modport slave (
    input req, req_gain, settle_cycles,
    output grant, amp_sel, amp_gain, amp_gain_we, amp_en, sample, done, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request after last, wrapping around
module rr_arbiter import amp_share_pkg::*; #(
  parameter int N_REQ = 4,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);
  logic [IDX_W-1:0] j;
  // farthest candidate first so the nearest one after last wins
  always_comb begin
    valid_o = 1'b0;
    idx_o = '0;
    j = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      j = IDX_W'((int'(last_i) + i) % N_REQ);
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/amp_share_scheduler.sv
// amp_share_scheduler: round-robin time-sharing of one gain stage; program, settle, sample, hand back
module amp_share_scheduler import amp_share_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int GAIN_W = 8,
  parameter int SETTLE_W = 8,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input logic clk,
  input logic rst,
  amp_share_scheduler_if.slave bus
);
  state_e state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] sel_q, sel_d, last_q, last_d, arb_idx;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic arb_valid, own_req;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i(bus.req),
    .last_i(last_q),
    .valid_o(arb_valid),
    .idx_o(arb_idx)
  );
  assign own_req = bus.req[sel_q];
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d = sel_q;
    last_d = last_q;
    cnt_d = cnt_q;
    gain_d = gain_q;
    case (state_q)
      IDLE: if (arb_valid) begin
        state_d = PROG;
        grant_d = N_REQ'(onehot(int'(arb_idx)));
        sel_d = arb_idx;
        last_d = arb_idx;
        cnt_d = bus.settle_cycles;
        gain_d = bus.req_gain[int'(arb_idx)*GAIN_W +: GAIN_W];
      end
      PROG: state_d = !own_req ? IDLE : (|cnt_q) ? SETTLE : SAMPLE;
      SETTLE: begin
        state_d = !own_req ? IDLE : (cnt_q == SETTLE_W'(1)) ? SAMPLE : SETTLE;
        cnt_d = cnt_q - SETTLE_W'(1);
      end
      SAMPLE: state_d = HOLD;
      HOLD: state_d = own_req ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
    // release and abort both drop ownership on the edge into IDLE
    if (state_d == IDLE) grant_d = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q <= '0;
      last_q <= IDX_W'(N_REQ - 1);
      cnt_q <= '0;
      gain_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q <= sel_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      gain_q <= gain_d;
    end
  end
  assign bus.grant = grant_q;
  assign bus.amp_sel = sel_q;
  assign bus.amp_gain = gain_q;
  assign bus.amp_gain_we = state_q == PROG;
  assign bus.amp_en = state_q inside {PROG, SETTLE, SAMPLE};
  assign bus.sample = state_q == SAMPLE;
  assign bus.done = grant_q & {N_REQ{state_q == SAMPLE}};
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_amp_share_scheduler.sv
// tb_amp_share_scheduler: vector table, directed corner sequences and random traffic against a timeline model
module tb_amp_share_scheduler;
  localparam int N = 4, G = 8, S = 8;
  logic clk = 1'b0;
  logic rst;
  int checks = 0, errors = 0;
  bit prev_sample = 1'b0, prev_done = 1'b0;
  always #5 clk = ~clk;
  amp_share_scheduler_if #(.N_REQ(N), .GAIN_W(G), .SETTLE_W(S)) bus ();
  amp_share_scheduler #(.N_REQ(N), .GAIN_W(G), .SETTLE_W(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  // model: owner plus cycles elapsed since grant; t==0 program, t<=s settle, t==s+1 sample, beyond that hold
  typedef struct packed {
    int owner;
    int t;
    int s;
    int sel;
    int last;
    logic [G-1:0] gain;
  } mdl_t;
  mdl_t m = '{owner: -1, t: 0, s: 0, sel: 0, last: N-1, gain: '0};

  function automatic mdl_t model_next(mdl_t c, logic r, logic [N-1:0] rq, logic [N*G-1:0] rg, logic [S-1:0] st);
    mdl_t n = c;
    if (r) begin
      n.owner = -1; n.sel = 0; n.gain = '0; n.last = N-1; n.t = 0; n.s = 0;
    end else if (c.owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int j = (c.last + k) % N;
        if (n.owner < 0 && rq[j]) begin
          n.owner = j; n.sel = j; n.last = j; n.t = 0; n.s = int'(st); n.gain = rg[j*G +: G];
        end
      end
    end else if (c.t == c.s + 1) n.t = c.t + 1;
    else if (!rq[c.owner]) n.owner = -1;
    else if (c.t <= c.s) n.t = c.t + 1;
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, rst, bus.req, bus.req_gain, bus.settle_cycles);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit a, p, smp, en;
    logic [N-1:0] g;
    @(posedge clk);
    #1;
    a = m.owner >= 0;
    p = a && m.t == 0;
    smp = a && m.t == m.s + 1;
    en = a && m.t <= m.s + 1;
    g = a ? N'(1) << m.owner : '0;
    chk("grant", bus.grant, g);
    chk("amp_sel", bus.amp_sel, m.sel);
    chk("amp_gain", bus.amp_gain, m.gain);
    chk("amp_gain_we", bus.amp_gain_we, p);
    chk("amp_en", bus.amp_en, en);
    chk("sample", bus.sample, smp);
    chk("done", bus.done, smp ? g : '0);
    chk("busy", bus.busy, a);
    chk("grant_onehot0", $onehot0(bus.grant), 1);
    chk("done_in_grant", bus.done & ~bus.grant, 0);
    chk("sample_repeat", prev_sample & bus.sample, 0);
    chk("done_repeat", prev_done & (|bus.done), 0);
    prev_sample = bus.sample;
    prev_done = |bus.done;
  endtask

  task automatic set_gain(int i, logic [G-1:0] g);
    bus.req_gain[i*G +: G] = g;
  endtask

  task automatic drain();
    bus.req = '0;
    for (int c = 0; c < 40 && bus.busy; c++) step();
    chk("drain_idle", bus.busy, 0);
  endtask

  typedef struct packed {
    logic [N-1:0] req;
    logic [S-1:0] settle;
    logic [N-1:0] grant;
    logic [1:0] sel;
    logic we, en, smp;
    logic [N-1:0] done;
    logic busy;
    logic [G-1:0] gain;
  } vec_t;
  vec_t tv[$];

  int order[$];
  int exp_rr[5] = '{0, 1, 2, 3, 0};
  logic [N-1:0] pg;
  bit pb;

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.settle_cycles = '0;
    bus.req_gain = '0;
    set_gain(0, 8'h2A); set_gain(1, 8'h10); set_gain(2, 8'h33); set_gain(3, 8'h44);
    step();
    chk("reset_grant", bus.grant, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_gain", bus.amp_gain, 0);
    chk("reset_sel", bus.amp_sel, 0);
    rst = 1'b0;
    step();

    // single request settle 3, then settle 0 on requester 1
    tv.push_back('{4'b0001, 8'd3, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h2A});
    tv.push_back('{4'b0001, 8'd3, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h2A});
    tv.push_back('{4'b0001, 8'd3, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h2A});
    tv.push_back('{4'b0001, 8'd3, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h2A});
    tv.push_back('{4'b0001, 8'd3, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1, 8'h2A});
    tv.push_back('{4'b0001, 8'd3, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h2A});
    tv.push_back('{4'b0000, 8'd3, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h2A});
    tv.push_back('{4'b0010, 8'd0, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h10});
    tv.push_back('{4'b0010, 8'd5, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 8'h10});
    tv.push_back('{4'b0010, 8'd5, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h10});
    tv.push_back('{4'b0000, 8'd5, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h10});
    tv.push_back('{4'b0000, 8'd5, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h10});
    foreach (tv[i]) begin
      bus.req = tv[i].req;
      bus.settle_cycles = tv[i].settle;
      step();
      chk("tv_grant", bus.grant, tv[i].grant);
      chk("tv_sel", bus.amp_sel, tv[i].sel);
      chk("tv_we", bus.amp_gain_we, tv[i].we);
      chk("tv_en", bus.amp_en, tv[i].en);
      chk("tv_sample", bus.sample, tv[i].smp);
      chk("tv_done", bus.done, tv[i].done);
      chk("tv_busy", bus.busy, tv[i].busy);
      chk("tv_gain", bus.amp_gain, tv[i].gain);
    end

    // round robin with all requesters active
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.settle_cycles = 8'd2;
    bus.req = '1;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      pb = bus.busy;
      pg = bus.grant;
      step();
      if (pg == 0 && bus.grant != 0) begin
        for (int i = 0; i < N; i++) if (bus.grant[i]) order.push_back(i);
        chk("rr_idle_gap", pb, 0);
      end
      if (|bus.done) bus.req = bus.req & ~bus.done;
      else if (bus.grant == 0) bus.req = '1;
    end
    chk("rr_count", order.size(), 5);
    for (int i = 0; i < 5; i++) chk("rr_order", order.size() > i ? order[i] : -1, exp_rr[i]);
    drain();

    // abort during settle, pointer stays at the aborted index
    bus.settle_cycles = 8'd10;
    bus.req = 4'b0100;
    step();
    chk("abort_grant", bus.grant, 4'b0100);
    step(); step(); step();
    bus.req = 4'b1001;
    step();
    chk("abort_busy", bus.busy, 0);
    chk("abort_grant_clr", bus.grant, 0);
    chk("abort_sample", bus.sample, 0);
    chk("abort_done", bus.done, 0);
    step();
    chk("abort_next", bus.grant, 4'b1000);
    drain();

    // reset while settling
    bus.settle_cycles = 8'd8;
    bus.req = 4'b0010;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gain", bus.amp_gain, 0);
    chk("rst_en", bus.amp_en, 0);
    chk("rst_sel", bus.amp_sel, 0);
    chk("rst_we", bus.amp_gain_we, 0);
    rst = 1'b0;
    bus.req = '1;
    step();
    chk("rst_first", bus.grant, 4'b0001);
    drain();

    // gain change after capture
    set_gain(1, 8'h10);
    bus.settle_cycles = 8'd3;
    bus.req = 4'b0010;
    step();
    chk("late_prog_gain", bus.amp_gain, 8'h10);
    step();
    set_gain(1, 8'h55);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("late_gain", bus.amp_gain, 8'h10);
      chk("late_we", bus.amp_gain_we, 0);
    end
    drain();
    step();
    chk("gain_kept", bus.amp_gain, 8'h10);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
      if ($urandom_range(0, 3) == 0) set_gain($urandom_range(0, N-1), G'($urandom));
      bus.settle_cycles = S'($urandom_range(0, 5));
      step();
    end
    rst = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
